nco_clk_gen: RTL and testbench
==============================

# nco_clk_gen

Multi-channel fractional clock generator built on per-channel phase accumulators (NCOs).
- Each channel produces a near-50 % duty square wave at f_clk·inc/2^ACC_W and a one-cycle end-of-period tick.
- Increments are programmable at runtime through a valid/ready port; updates apply glitch-free at the next period boundary.
- Used in the LTC simulation path to derive bit, frame and sampling clocks from one system clock.

## Interface
- CHANNELS, 2, number of independent output channels (1..16)
- ACC_W, 32, accumulator / increment width in bits (8..48)
- CH_W, $clog2(CHANNELS) min 1, width of channel select (derived, not overridden)
- clk_i  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- en_i  in  CHANNELS  per-channel run enable
- sync_i  in  1  one-cycle pulse: phase-align all channels
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  config request can be accepted
- cfg_ch  in  CH_W  target channel
- cfg_inc  in  ACC_W  new phase increment
- clk_o  out  CHANNELS  generated clocks, registered
- tick_o  out  CHANNELS  one-cycle pulse per channel on period wrap, registered

## Operation
- Per-channel state: acc[ACC_W], inc[ACC_W], shadow[ACC_W], pending (1 bit).
- Reset (reset_n=0 at clk edge) sets:
  - acc=0, inc=0, shadow=0, pending=0
  - clk_o=0, tick_o=0
  - cfg_ready=1 after reset
- Running (en_i[c]=1): {carry, acc} <= acc + inc, computed ACC_W+1 wide.
  - clk_o[c] <= MSB of new acc.
  - tick_o[c] <= carry.
- Disabled (en_i[c]=0): acc holds; clk_o[c] <= 0; tick_o[c] <= 0. Re-enable resumes from the held phase.
- inc=0 with en=1: acc holds, clk_o holds acc MSB, no ticks.
- Clamp: a written value > 2^(ACC_W-1) is stored as 2^(ACC_W-1) (f_clk/2). Values ≤ 2^(ACC_W-1) are stored unchanged.
- Config handshake: a transfer occurs when cfg_valid & cfg_ready at a clock edge.
  - cfg_ready = ~pending[cfg_ch], combinational from cfg_ch.
  - cfg_ch ≥ CHANNELS: cfg_ready=1, request accepted and dropped.
  - Accepted write: shadow <= clamped cfg_inc, pending <= 1.
- Shadow apply (inc <= shadow, pending <= 0) happens on the first edge where any of these holds:
  - the channel wraps (carry=1); the new inc takes effect from the following cycle
  - en_i[c]=0
  - inc=0
  - sync_i=1
- Same-edge apply and accept: apply has priority. pending clears; the new request is blocked because cfg_ready was low.
- sync_i=1: all acc <= 0, all clk_o <= 0, all tick_o <= 0, all pending shadows applied. Overrides accumulation in that cycle.
- Reset mid-period or mid-handshake: all state is discarded, including pending writes.

## Timing
- Output latency: clk_o/tick_o reflect the accumulator value produced at the same edge, so one register stage after inputs.
- Period: tick_o[c] fires on the edge where clk_o[c] falls 1→0.
  - Long-run mean period is 2^ACC_W/inc cycles.
  - Instantaneous period is floor or ceil of that value.
- en_i rise to first tick: ceil(2^ACC_W/inc) cycles from acc=0.
- Config write to new frequency: latency ≤ one current period + 1 cycle.
- Channels are fully independent except for the shared sync_i and cfg port.

## Test plan
- ACC_W=32, ch0 inc=0x4000_0000, en_i=1 → clk_o[0] sequence 0,1,1,0 repeating; tick_o[0] on every 4th cycle, coincident with clk_o falling.
- inc=0x6000_0000 from acc=0 → ticks at cycles 3, 6, 8, then the pattern repeats; 3 ticks per 8 cycles.
- cfg_inc=0xFFFF_FFFF → stored 0x8000_0000; clk_o toggles every cycle; tick every 2 cycles.
- Mid-period write of 0x2000_0000 over 0x4000_0000:
  - cfg_ready for ch0 drops the next cycle.
  - Old 4-cycle period completes; next period is 8 cycles.
  - cfg_ready returns to 1 after the wrap.
- Two channels with incs 0x4000_0000 and 0x2000_0000 running, sync_i pulse → both acc=0, clk_o=0; ch0 ticks 4 cycles later, ch1 ticks 8 cycles later.
- reset_n low mid-operation with pending=1 → next cycle all clk_o=0, tick_o=0, cfg_ready=1; after release with en=1, no ticks occur because inc=0.

Source files
------------

// File: rtl/nco_clk_gen.sv
// Multi-channel fractional clock generator: one phase accumulator per channel,
// with runtime increment updates staged in a shadow register until a period boundary.
module nco_clk_gen #(
   parameter int CHANNELS = 2,
   parameter int ACC_W    = 32,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_i,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] en_i,
   input  logic                sync_i,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [ACC_W-1:0]    cfg_inc,
   output logic [CHANNELS-1:0] clk_o,
   output logic [CHANNELS-1:0] tick_o
);

   localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W-1:0]    acc_q    [CHANNELS];
   logic [ACC_W-1:0]    acc_d    [CHANNELS];
   logic [ACC_W-1:0]    inc_q    [CHANNELS];
   logic [ACC_W-1:0]    inc_d    [CHANNELS];
   logic [ACC_W-1:0]    shadow_q [CHANNELS];
   logic [ACC_W-1:0]    shadow_d [CHANNELS];
   logic [ACC_W:0]      sum      [CHANNELS];
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] clk_q, clk_d;
   logic [CHANNELS-1:0] tick_q, tick_d;
   logic [CHANNELS-1:0] apply, accept;
   logic [ACC_W-1:0]    inc_clamped;

   assign inc_clamped = (cfg_inc > INC_MAX) ? INC_MAX : cfg_inc;

   // An out-of-range channel matches no slot, so it stays ready and is dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
         if (cfg_ch == CH_W'(c)) cfg_ready = ~pending_q[c];
      end
   end

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         sum[c]      = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
         acc_d[c]    = acc_q[c];
         inc_d[c]    = inc_q[c];
         shadow_d[c] = shadow_q[c];
         pending_d[c] = pending_q[c];
         clk_d[c]    = 1'b0;
         tick_d[c]   = 1'b0;

         apply[c]  = pending_q[c] & (sync_i | ~en_i[c] | (inc_q[c] == '0) | sum[c][ACC_W]);
         accept[c] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(c));

         if (sync_i) begin
            acc_d[c] = '0;
         end else if (en_i[c]) begin
            acc_d[c]  = sum[c][ACC_W-1:0];
            clk_d[c]  = sum[c][ACC_W-1];
            tick_d[c] = sum[c][ACC_W];
         end

         // Apply wins over accept; both can't hit one channel anyway since ready is low while pending.
         if (apply[c]) begin
            inc_d[c]     = shadow_q[c];
            pending_d[c] = 1'b0;
         end else if (accept[c]) begin
            shadow_d[c]  = inc_clamped;
            pending_d[c] = 1'b1;
         end
      end
   end

   // NOTE: per-channel state lives in flops, not RAM, so every entry is cleared by reset.
   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            acc_q[c]    <= '0;
            inc_q[c]    <= '0;
            shadow_q[c] <= '0;
         end
         pending_q <= '0;
         clk_q     <= '0;
         tick_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
         for (int c = 0; c < CHANNELS; c++) begin
            acc_q[c]    <= acc_d[c];
            inc_q[c]    <= inc_d[c];
            shadow_q[c] <= shadow_d[c];
         end
         pending_q <= pending_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;

endmodule

// File: tb/tb_nco_clk_gen.sv
// Directed bench for nco_clk_gen: a vector table for programming, running, mid-period
// writes and enable gating, plus hand-written sequences for rate patterns, clamp, sync and reset.
module tb_nco_clk_gen;

   localparam int CHANNELS = 2;
   localparam int ACC_W    = 32;
   localparam int CH_W     = 1;

   logic                clk_i = 1'b0;
   logic                reset_n;
   logic [CHANNELS-1:0] en_i;
   logic                sync_i;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [CH_W-1:0]     cfg_ch;
   logic [ACC_W-1:0]    cfg_inc;
   logic [CHANNELS-1:0] clk_o;
   logic [CHANNELS-1:0] tick_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  en;
      logic        valid;
      logic        ch;
      logic [31:0] inc;
      logic [1:0]  exp_clk;
      logic [1:0]  exp_tick;
      logic        exp_ready;
   } vec_t;

   vec_t vecs[$];

   nco_clk_gen #(.CHANNELS(CHANNELS), .ACC_W(ACC_W)) dut (
      .clk_i     (clk_i),
      .reset_n   (reset_n),
      .en_i      (en_i),
      .sync_i    (sync_i),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .clk_o     (clk_o),
      .tick_o    (tick_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic add(input logic [1:0] en, input logic valid, input logic ch, input logic [31:0] inc,
                      input logic [1:0] ec, input logic [1:0] et, input logic er);
      vec_t v;
      v.en = en; v.valid = valid; v.ch = ch; v.inc = inc;
      v.exp_clk = ec; v.exp_tick = et; v.exp_ready = er;
      vecs.push_back(v);
   endtask

   // Write with the channels stopped: accepted on the first edge, applied on the second.
   task automatic program_inc(input logic ch, input logic [31:0] val);
      en_i = '0; cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = val;
      step();
      cfg_valid = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] a_clk;
      logic [7:0] a_tick;
      logic [1:0] c_clk  [8];
      logic [1:0] c_tick [8];
      int         tick_cnt;
      logic [1:0] clk_seen;

      reset_n = 1'b0; en_i = '0; sync_i = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
      step(); step();
      check("reset clk_o", clk_o, 2'b00);
      check("reset tick_o", tick_o, 2'b00);
      check("reset cfg_ready", cfg_ready, 1'b1);
      reset_n = 1'b1;

      // Program ch0=0x4000_0000, ch1=0x2000_0000 while stopped.
      add(2'b00, 1, 0, 32'h4000_0000, 2'b00, 2'b00, 0);
      add(2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 1);
      add(2'b00, 1, 1, 32'h2000_0000, 2'b00, 2'b00, 0);
      add(2'b00, 0, 1, 32'h0,         2'b00, 2'b00, 1);
      // ch0 quarter rate: clk 0,1,1,0 with tick on the falling cycle.
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b01, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b01, 1);
      // Mid-period write of 0x2000_0000: old period completes, then an 8-cycle period.
      add(2'b01, 1, 0, 32'h2000_0000, 2'b00, 2'b00, 0);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 0);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 0);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b01, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b01, 1);
      // Disable holds the phase (0x8000_0000) and forces outputs low; re-enable resumes.
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b00, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b00, 0, 0, 32'h0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b01, 2'b00, 1);
      add(2'b01, 0, 0, 32'h0, 2'b00, 2'b01, 1);

      foreach (vecs[i]) begin
         en_i = vecs[i].en; cfg_valid = vecs[i].valid; cfg_ch = vecs[i].ch; cfg_inc = vecs[i].inc;
         step();
         check($sformatf("vec%0d clk_o", i), clk_o, vecs[i].exp_clk);
         check($sformatf("vec%0d tick_o", i), tick_o, vecs[i].exp_tick);
         check($sformatf("vec%0d cfg_ready", i), cfg_ready, vecs[i].exp_ready);
      end
      cfg_valid = 1'b0; en_i = '0;

      // 0x6000_0000 from acc=0: ticks on cycles 3, 6, 8.
      program_inc(1'b0, 32'h6000_0000);
      sync_i = 1'b1; step(); sync_i = 1'b0;
      a_clk  = 8'b0101_1010;
      a_tick = 8'b1010_0100;
      en_i = 2'b01;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("rate6 clk c%0d", i + 1), clk_o, {1'b0, a_clk[i]});
         check($sformatf("rate6 tick c%0d", i + 1), tick_o, {1'b0, a_tick[i]});
      end
      tick_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         tick_cnt += int'(tick_o[0]);
      end
      check("rate6 ticks per 8", tick_cnt, 3);

      // Oversized increment clamps to half rate.
      program_inc(1'b0, 32'hFFFF_FFFF);
      sync_i = 1'b1; step(); sync_i = 1'b0;
      en_i = 2'b01;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("clamp clk c%0d", i + 1), clk_o, {1'b0, (i % 2 == 0)});
         check($sformatf("clamp tick c%0d", i + 1), tick_o, {1'b0, (i % 2 == 1)});
      end

      // Sync phase-aligns both running channels.
      program_inc(1'b0, 32'h4000_0000);
      en_i = 2'b11;
      step(); step(); step();
      sync_i = 1'b1; step(); sync_i = 1'b0;
      check("sync clk_o", clk_o, 2'b00);
      check("sync tick_o", tick_o, 2'b00);
      c_clk  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
      c_tick = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("post-sync clk c%0d", i + 1), clk_o, c_clk[i]);
         check($sformatf("post-sync tick c%0d", i + 1), tick_o, c_tick[i]);
      end

      // Reset with a write pending discards everything; inc=0 afterwards means no ticks.
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 32'h1000_0000;
      step();
      cfg_valid = 1'b0;
      check("pending cfg_ready", cfg_ready, 1'b0);
      reset_n = 1'b0;
      step();
      check("mid reset clk_o", clk_o, 2'b00);
      check("mid reset tick_o", tick_o, 2'b00);
      check("mid reset cfg_ready", cfg_ready, 1'b1);
      reset_n = 1'b1;
      tick_cnt = 0;
      clk_seen = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         tick_cnt += int'(tick_o[0]) + int'(tick_o[1]);
         clk_seen |= clk_o;
      end
      check("after reset ticks", tick_cnt, 0);
      check("after reset clk_o", clk_seen, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
